mips_execute_stage: RTL and testbench
=====================================

// Module: mips_execute_stage
// PURPOSE
//  EX stage of the 5-stage MIPS pipeline, between the ID/EX and MEM stages. Contains:
//   - operand forwarding;
//   - the ALU;
//   - branch resolution;
//   - the EX/MEM pipeline register.
//  Branch/dest outputs are combinational (feed fetch flush and load-use hazard unit); mem_* outputs are registered.
// PARAMETERS
//  XLEN    32  datapath width
//  REG_AW  5   register address width
// PORTS
//  clk             in   1     single clock, all state on rising edge
//  reset           in   1     synchronous, active-low
//  ex_pc4          in   XLEN  PC+4 of EX instruction
//  ex_mem_to_reg   in   1     ID/EX control: writeback selects memory data
//  ex_reg_write    in   1     ID/EX control: instruction writes a register
//  ex_mem_write    in   1     ID/EX control: store
//  ex_mem_read     in   1     ID/EX control: load
//  ex_alu_op       in   4     ALU operation class
//  ex_alu_src      in   1     1: operand B = ex_imm
//  ex_reg_dst      in   1     1: dest = rd, 0: dest = rt
//  ex_branch       in   2     00 none, 01 BEQ, 10 BNE, 11 none
//  ex_imm          in   XLEN  sign-extended immediate
//  ex_rs_addr      in   REG_AW  rs register address
//  ex_rt_addr      in   REG_AW  rt register address
//  ex_rd_addr      in   REG_AW  rd register address
//  ex_rs_data      in   XLEN  register-file value of rs
//  ex_rt_data      in   XLEN  register-file value of rt
//  ex_funct        in   6     R-type funct
//  wb_reg_write    in   1     WB-stage write enable
//  wb_write_addr   in   REG_AW  WB-stage dest address
//  wb_write_data   in   XLEN  WB-stage write data
//  ex_dest_addr    out  REG_AW  combinational dest address (to hazard unit)
//  ex_alu_zero     out  1     combinational, ALU result == 0
//  branch_taken    out  1     combinational, flushes IF/ID and ID/EX
//  branch_target   out  XLEN  ex_pc4 + (ex_imm << 2)
//  fwd_a           out  2     forward select, operand A (debug)
//  fwd_b           out  2     forward select, operand B (debug)
//  mem_mem_to_reg  out  1     registered copy of ex_mem_to_reg
//  mem_reg_write   out  1     registered copy of ex_reg_write
//  mem_mem_write   out  1     registered copy of ex_mem_write
//  mem_mem_read    out  1     registered copy of ex_mem_read
//  mem_alu_result  out  XLEN  registered ALU result
//  mem_write_data  out  XLEN  registered store data
//  mem_dest_addr   out  REG_AW  registered dest address
// BEHAVIOUR
//  - Forwarding, per operand, for source address s in {rs, rt}:
//     - 2'b10 (EX/MEM) if mem_reg_write && mem_dest_addr != 0 && mem_dest_addr == s;
//     - else 2'b01 (WB) if wb_reg_write && wb_write_addr != 0 && wb_write_addr == s;
//     - else 2'b00 (register file);
//     - EX/MEM has priority.
//     - Mux data: 00 = ex_*_data, 01 = wb_write_data, 10 = mem_alu_result.
//  - Operand A = forwarded rs.
//  - Operand B = ex_alu_src ? ex_imm : forwarded rt.
//  - Store data = forwarded rt, independent of ALUSrc.
//  - ex_alu_op codes:
//     - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT (signed), 0101 LUI (B << 16);
//     - 1111 RTYPE: decode by ex_funct;
//     - any other code -> result 0.
//  - RTYPE funct, in hex:
//     - 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu;
//     - 00 sll, 02 srl, 03 sra: shift operand B by shamt = ex_imm[10:6];
//     - any other funct -> result 0.
//  - Arithmetic wraps modulo 2^XLEN; no overflow trap.
//  - Branch:
//     - eq = (forwarded rs == forwarded rt);
//     - branch_taken = (BEQ & eq) | (BNE & ~eq).
//     - branch_target is always computed.
//  - ex_dest_addr = ex_reg_dst ? ex_rd_addr : ex_rt_addr.
//  - EX/MEM register, on rising clk:
//     - if !reset: all mem_* outputs <= 0;
//     - else: capture controls, ALU result, store data, dest address.
//     - No stall or flush input: the ID/EX bubble arrives as zero controls.
//  - Reset mid-operation: the in-flight EX/MEM entry is discarded next edge; combinational outputs continue to follow the inputs.
// CONFIGURATION
//  EX_FORWARDING_EN:
//   - defined: forwarding as above;
//   - undefined: fwd_a = fwd_b = 2'b00, operands always from the register file; the compiler/stall logic must cover RAW hazards.
// STRUCTURE
//  - Package mips_ex_pkg:
//     - alu_op_e, branch_e, fwd_sel_e enums;
//     - funct constants;
//     - XLEN and REG_AW.
//  - Sub-module ex_forward_unit: pure combinational fwd_a/fwd_b generation.
//  - ALU, branch logic and EX/MEM register are inline.
// TESTING
//  1. reset=0 for one edge after random traffic -> all mem_* = 0.
//  2. RTYPE funct 0x20, rs_data=5, rt_data=7, rd=9, reg_dst=1, reg_write=1 -> next edge mem_alu_result=12, mem_dest_addr=9, mem_reg_write=1.
//  3. Prior instruction writes r3=10; current rs=3 with stale rs_data=0 -> fwd_a=10, result uses 10.
//     Same address also in WB -> EX/MEM still wins.
//     Dest addr 0 -> no forward.
//  4. BEQ with rs=rt=4, ex_pc4=0x100, ex_imm=3 -> branch_taken=1, branch_target=0x10C.
//     Same with BNE -> 0.
//     Branch code 11 -> 0.
//  5. SLT with A=0xFFFFFFFF, B=1 -> result 1; SLTU -> 0.
//     sll with rt=1, shamt=4 -> 0x10.
//  6. Store: alu_src=1, ex_imm=8, rt forwarded from WB=0xABCD -> mem_write_data=0xABCD, mem_alu_result=rs+8.

Source files
------------

// File: rtl/mips_execute_stage_pkg.sv
// Shared types and constants for the MIPS EX stage: ALU op classes, branch kinds,
// forward selects and R-type funct codes.
package mips_ex_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_SLT   = 4'b0100,
    ALU_LUI   = 4'b0101,
    ALU_RTYPE = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_BEQ   = 2'b01,
    BR_BNE   = 2'b10,
    BR_NONE3 = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/mips_execute_stage_if.sv
// Bundle of ID/EX inputs, WB feedback, EX combinational outputs and EX/MEM register outputs.
// Handshake: none; every input is sampled each cycle, a bubble is an all-zero control word.
interface mips_execute_stage_if #(
  parameter int XLEN   = mips_ex_pkg::XLEN,
  parameter int REG_AW = mips_ex_pkg::REG_AW
);
  logic [XLEN-1:0]   ex_pc4;
  logic              ex_mem_to_reg;
  logic              ex_reg_write;
  logic              ex_mem_write;
  logic              ex_mem_read;
  logic [3:0]        ex_alu_op;
  logic              ex_alu_src;
  logic              ex_reg_dst;
  logic [1:0]        ex_branch;
  logic [XLEN-1:0]   ex_imm;
  logic [REG_AW-1:0] ex_rs_addr;
  logic [REG_AW-1:0] ex_rt_addr;
  logic [REG_AW-1:0] ex_rd_addr;
  logic [XLEN-1:0]   ex_rs_data;
  logic [XLEN-1:0]   ex_rt_data;
  logic [5:0]        ex_funct;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_write_addr;
  logic [XLEN-1:0]   wb_write_data;
  logic [REG_AW-1:0] ex_dest_addr;
  logic              ex_alu_zero;
  logic              branch_taken;
  logic [XLEN-1:0]   branch_target;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_mem_to_reg;
  logic              mem_reg_write;
  logic              mem_mem_write;
  logic              mem_mem_read;
  logic [XLEN-1:0]   mem_alu_result;
  logic [XLEN-1:0]   mem_write_data;
  logic [REG_AW-1:0] mem_dest_addr;

  modport master (
    output ex_pc4, ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_op,
           ex_alu_src, ex_reg_dst, ex_branch, ex_imm, ex_rs_addr, ex_rt_addr, ex_rd_addr,
           ex_rs_data, ex_rt_data, ex_funct, wb_reg_write, wb_write_addr, wb_write_data,
    input  ex_dest_addr, ex_alu_zero, branch_taken, branch_target, fwd_a, fwd_b,
           mem_mem_to_reg, mem_reg_write, mem_mem_write, mem_mem_read, mem_alu_result,
           mem_write_data, mem_dest_addr
  );

  modport slave (
    input  ex_pc4, ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_op,
           ex_alu_src, ex_reg_dst, ex_branch, ex_imm, ex_rs_addr, ex_rt_addr, ex_rd_addr,
           ex_rs_data, ex_rt_data, ex_funct, wb_reg_write, wb_write_addr, wb_write_data,
    output ex_dest_addr, ex_alu_zero, branch_taken, branch_target, fwd_a, fwd_b,
           mem_mem_to_reg, mem_reg_write, mem_mem_write, mem_mem_read, mem_alu_result,
           mem_write_data, mem_dest_addr
  );
endinterface

// File: rtl/mips_execute_stage_forward.sv
// Operand forward-select generation; EX/MEM beats WB, register 0 never forwards.
// Compiled out to register-file-only selects unless EX_FORWARDING_EN is defined.
module ex_forward_unit
  import mips_ex_pkg::*;
#(
  parameter int REG_AW = mips_ex_pkg::REG_AW
) (
  input  logic              memRegWrite,
  input  logic [REG_AW-1:0] memDestAddr,
  input  logic              wbRegWrite,
  input  logic [REG_AW-1:0] wbWriteAddr,
  input  logic [REG_AW-1:0] rsAddr,
  input  logic [REG_AW-1:0] rtAddr,
  output fwd_sel_e          fwdA,
  output fwd_sel_e          fwdB
);
`ifdef EX_FORWARDING_EN
  function automatic fwd_sel_e pickSource(input logic [REG_AW-1:0] src,
                                          input logic memWe, input logic [REG_AW-1:0] memAddr,
                                          input logic wbWe, input logic [REG_AW-1:0] wbAddr);
    if (memWe && memAddr != '0 && memAddr == src)     return FWD_MEM;
    else if (wbWe && wbAddr != '0 && wbAddr == src)   return FWD_WB;
    else                                              return FWD_RF;
  endfunction

  assign fwdA = pickSource(rsAddr, memRegWrite, memDestAddr, wbRegWrite, wbWriteAddr);
  assign fwdB = pickSource(rtAddr, memRegWrite, memDestAddr, wbRegWrite, wbWriteAddr);
`else
  logic unusedInputs;
  assign unusedInputs = ^{memRegWrite, memDestAddr, wbRegWrite, wbWriteAddr, rsAddr, rtAddr};
  assign fwdA = FWD_RF;
  assign fwdB = FWD_RF;
`endif
endmodule

// File: rtl/mips_execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Forwarding is present only when EX_FORWARDING_EN is defined.
module mips_execute_stage
  import mips_ex_pkg::*;
#(
  parameter int XLEN   = mips_ex_pkg::XLEN,
  parameter int REG_AW = mips_ex_pkg::REG_AW
) (
  input logic                clk,
  input logic                reset,
  mips_execute_stage_if.slave ex
);
  fwd_sel_e          fwdA, fwdB;
  logic [XLEN-1:0]   opA, rtFwd, opB, aluResult;
  logic [4:0]        shamt;
  logic              eq;

  ex_forward_unit #(.REG_AW(REG_AW)) u_fwd (
    .memRegWrite (ex.mem_reg_write),
    .memDestAddr (ex.mem_dest_addr),
    .wbRegWrite  (ex.wb_reg_write),
    .wbWriteAddr (ex.wb_write_addr),
    .rsAddr      (ex.ex_rs_addr),
    .rtAddr      (ex.ex_rt_addr),
    .fwdA        (fwdA),
    .fwdB        (fwdB)
  );

  always_comb begin
    opA = ex.ex_rs_data;
    case (fwdA)
      FWD_WB:  opA = ex.wb_write_data;
      FWD_MEM: opA = ex.mem_alu_result;
      default: opA = ex.ex_rs_data;
    endcase
    rtFwd = ex.ex_rt_data;
    case (fwdB)
      FWD_WB:  rtFwd = ex.wb_write_data;
      FWD_MEM: rtFwd = ex.mem_alu_result;
      default: rtFwd = ex.ex_rt_data;
    endcase
  end

  // Store data always takes the forwarded rt, even when B is the immediate.
  assign opB   = ex.ex_alu_src ? ex.ex_imm : rtFwd;
  assign shamt = ex.ex_imm[10:6];

  always_comb begin
    aluResult = '0;
    case (alu_op_e'(ex.ex_alu_op))
      ALU_ADD: aluResult = opA + opB;
      ALU_SUB: aluResult = opA - opB;
      ALU_AND: aluResult = opA & opB;
      ALU_OR:  aluResult = opA | opB;
      ALU_SLT: aluResult = {{(XLEN-1){1'b0}}, $signed(opA) < $signed(opB)};
      ALU_LUI: aluResult = opB << 16;
      ALU_RTYPE: begin
        case (ex.ex_funct)
          FN_ADD, FN_ADDU: aluResult = opA + opB;
          FN_SUB, FN_SUBU: aluResult = opA - opB;
          FN_AND:  aluResult = opA & opB;
          FN_OR:   aluResult = opA | opB;
          FN_XOR:  aluResult = opA ^ opB;
          FN_NOR:  aluResult = ~(opA | opB);
          FN_SLT:  aluResult = {{(XLEN-1){1'b0}}, $signed(opA) < $signed(opB)};
          FN_SLTU: aluResult = {{(XLEN-1){1'b0}}, opA < opB};
          FN_SLL:  aluResult = opB << shamt;
          FN_SRL:  aluResult = opB >> shamt;
          FN_SRA:  aluResult = $signed(opB) >>> shamt;
          default: aluResult = '0;
        endcase
      end
      default: aluResult = '0;
    endcase
  end

  assign eq               = (opA == rtFwd);
  assign ex.branch_taken  = (branch_e'(ex.ex_branch) == BR_BEQ &&  eq) ||
                            (branch_e'(ex.ex_branch) == BR_BNE && !eq);
  assign ex.branch_target = ex.ex_pc4 + (ex.ex_imm << 2);
  assign ex.ex_alu_zero   = (aluResult == '0);
  assign ex.ex_dest_addr  = ex.ex_reg_dst ? ex.ex_rd_addr : ex.ex_rt_addr;
  assign ex.fwd_a         = fwdA;
  assign ex.fwd_b         = fwdB;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex.mem_mem_to_reg <= 1'b0;
      ex.mem_reg_write  <= 1'b0;
      ex.mem_mem_write  <= 1'b0;
      ex.mem_mem_read   <= 1'b0;
      ex.mem_alu_result <= '0;
      ex.mem_write_data <= '0;
      ex.mem_dest_addr  <= '0;
    end else begin
      ex.mem_mem_to_reg <= ex.ex_mem_to_reg;
      ex.mem_reg_write  <= ex.ex_reg_write;
      ex.mem_mem_write  <= ex.ex_mem_write;
      ex.mem_mem_read   <= ex.ex_mem_read;
      ex.mem_alu_result <= aluResult;
      ex.mem_write_data <= rtFwd;
      ex.mem_dest_addr  <= ex.ex_dest_addr;
    end
  end
endmodule

// File: tb/tb_mips_execute_stage.sv
// Self-checking bench for mips_execute_stage: directed cases plus random traffic
// against an arithmetic reference model of the EX stage.
module tb_mips_execute_stage;
`ifdef EX_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   nChecks = 0;
  int   nErrors = 0;

  mips_execute_stage_if bus ();

  mips_execute_stage dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model's view of the EX/MEM register
  logic        mRegWrite, mMemToReg, mMemWrite, mMemRead;
  logic [31:0] mRes, mStore;
  logic [4:0]  mDest;
  // model's expectation for the entry being computed this cycle
  logic [31:0] eRes, eStore;
  logic [4:0]  eDest;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh);
    longint unsigned ua = a, ub = b, p = 64'd1 << sh;
    longint sa = $signed(a), sb = $signed(b);
    case (op)
      4'd0: return 32'(ua + ub);
      4'd1: return 32'(ua - ub);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return (sa < sb) ? 32'd1 : 32'd0;
      4'd5: return 32'(ub * 65536);
      4'd15: begin
        case (fn)
          6'h20, 6'h21: return 32'(ua + ub);
          6'h22, 6'h23: return 32'(ua - ub);
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
          6'h2B: return (ua < ub) ? 32'd1 : 32'd0;
          6'h00: return 32'(ub * p);
          6'h02: return 32'(ub / p);
          6'h03: return (sb < 0) ? ~32'((~ub & 64'hFFFF_FFFF) / p) : 32'(ub / p);
          default: return 32'd0;
        endcase
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (!FWD_ON) return 2'd0;
    if (mRegWrite && mDest != 0 && mDest == src) return 2'd2;
    if (bus.wb_reg_write && bus.wb_write_addr != 0 && bus.wb_write_addr == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] fwd_value(input logic [1:0] sel, input logic [31:0] rf);
    return (sel == 2'd2) ? mRes : (sel == 2'd1) ? bus.wb_write_data : rf;
  endfunction

  task automatic clear_inputs();
    bus.ex_pc4 = 0; bus.ex_mem_to_reg = 0; bus.ex_reg_write = 0; bus.ex_mem_write = 0;
    bus.ex_mem_read = 0; bus.ex_alu_op = 0; bus.ex_alu_src = 0; bus.ex_reg_dst = 0;
    bus.ex_branch = 0; bus.ex_imm = 0; bus.ex_rs_addr = 0; bus.ex_rt_addr = 0;
    bus.ex_rd_addr = 0; bus.ex_rs_data = 0; bus.ex_rt_data = 0; bus.ex_funct = 0;
    bus.wb_reg_write = 0; bus.wb_write_addr = 0; bus.wb_write_data = 0;
  endtask

  task automatic rand_inputs();
    logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15, 4'd15, 4'd15, 4'd9};
    logic [5:0] fns [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3F};
    bus.ex_pc4 = $urandom & 32'hFFFF_FFFC;
    bus.ex_mem_to_reg = 1'($urandom); bus.ex_reg_write = 1'($urandom);
    bus.ex_mem_write = 1'($urandom);  bus.ex_mem_read = 1'($urandom);
    bus.ex_alu_op = ops[$urandom_range(0, 9)];
    bus.ex_funct  = fns[$urandom_range(0, 14)];
    bus.ex_alu_src = 1'($urandom); bus.ex_reg_dst = 1'($urandom);
    bus.ex_branch = 2'($urandom);
    bus.ex_imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 2047));
    bus.ex_rs_addr = 5'($urandom_range(0, 3)); bus.ex_rt_addr = 5'($urandom_range(0, 3));
    bus.ex_rd_addr = 5'($urandom_range(0, 3));
    bus.ex_rs_data = ($urandom_range(0, 3) == 0) ? bus.ex_rt_data : $urandom;
    bus.ex_rt_data = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
    bus.wb_reg_write = 1'($urandom); bus.wb_write_addr = 5'($urandom_range(0, 3));
    bus.wb_write_data = $urandom;
  endtask

  // Evaluate combinational outputs for the inputs currently driven.
  task automatic settle_check();
    logic [1:0]  fa, fb;
    logic [31:0] a, rt, b;
    logic        taken;
    #1;
    fa = ref_fwd(bus.ex_rs_addr);
    fb = ref_fwd(bus.ex_rt_addr);
    a  = fwd_value(fa, bus.ex_rs_data);
    rt = fwd_value(fb, bus.ex_rt_data);
    b  = bus.ex_alu_src ? bus.ex_imm : rt;
    eRes   = ref_alu(bus.ex_alu_op, bus.ex_funct, a, b, bus.ex_imm[10:6]);
    eStore = rt;
    eDest  = bus.ex_reg_dst ? bus.ex_rd_addr : bus.ex_rt_addr;
    taken  = (bus.ex_branch == 2'b01 && a == rt) || (bus.ex_branch == 2'b10 && a != rt);
    check("fwd_a", 32'(bus.fwd_a), 32'(fa));
    check("fwd_b", 32'(bus.fwd_b), 32'(fb));
    check("ex_dest_addr", 32'(bus.ex_dest_addr), 32'(eDest));
    check("ex_alu_zero", 32'(bus.ex_alu_zero), (eRes == 0) ? 32'd1 : 32'd0);
    check("branch_taken", 32'(bus.branch_taken), 32'(taken));
    check("branch_target", bus.branch_target, 32'(bus.ex_pc4 + bus.ex_imm * 4));
  endtask

  // Clock the EX/MEM register and compare it with the model, then return to negedge.
  task automatic clock_check();
    @(posedge clk);
    if (!reset) begin
      {mRegWrite, mMemToReg, mMemWrite, mMemRead} = 4'b0;
      mRes = 0; mStore = 0; mDest = 0;
    end else begin
      mRegWrite = bus.ex_reg_write; mMemToReg = bus.ex_mem_to_reg;
      mMemWrite = bus.ex_mem_write; mMemRead = bus.ex_mem_read;
      mRes = eRes; mStore = eStore; mDest = eDest;
    end
    #1;
    check("mem_mem_to_reg", 32'(bus.mem_mem_to_reg), 32'(mMemToReg));
    check("mem_reg_write", 32'(bus.mem_reg_write), 32'(mRegWrite));
    check("mem_mem_write", 32'(bus.mem_mem_write), 32'(mMemWrite));
    check("mem_mem_read", 32'(bus.mem_mem_read), 32'(mMemRead));
    check("mem_alu_result", bus.mem_alu_result, mRes);
    check("mem_write_data", bus.mem_write_data, mStore);
    check("mem_dest_addr", 32'(bus.mem_dest_addr), 32'(mDest));
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    clock_check();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    {mRegWrite, mMemToReg, mMemWrite, mMemRead} = 4'b0;
    mRes = 0; mStore = 0; mDest = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    reset = 1'b1;

    // reset after random traffic clears the whole EX/MEM entry
    for (int i = 0; i < 5; i++) begin rand_inputs(); bus.ex_reg_write = 1'b1; step(); end
    rand_inputs(); bus.ex_reg_write = 1'b1; bus.ex_rs_data = 32'h1234; reset = 1'b0;
    step();
    check("rst_mem_alu_result", bus.mem_alu_result, 32'd0);
    check("rst_mem_reg_write", 32'(bus.mem_reg_write), 32'd0);
    reset = 1'b1;

    // R-type add into rd
    clear_inputs(); step();
    bus.ex_alu_op = 4'hF; bus.ex_funct = 6'h20; bus.ex_rs_addr = 1; bus.ex_rt_addr = 2;
    bus.ex_rs_data = 5; bus.ex_rt_data = 7; bus.ex_rd_addr = 9; bus.ex_reg_dst = 1;
    bus.ex_reg_write = 1;
    step();
    check("add_result", bus.mem_alu_result, 32'd12);
    check("add_dest", 32'(bus.mem_dest_addr), 32'd9);
    check("add_reg_write", 32'(bus.mem_reg_write), 32'd1);

    // producer writes r3 = 10, consumer reads r3 with stale data; WB also holds r3
    clear_inputs();
    bus.ex_alu_op = 4'hF; bus.ex_funct = 6'h20; bus.ex_rs_data = 4; bus.ex_rt_data = 6;
    bus.ex_rs_addr = 1; bus.ex_rt_addr = 2; bus.ex_rd_addr = 3; bus.ex_reg_dst = 1;
    bus.ex_reg_write = 1;
    step();
    clear_inputs();
    bus.ex_rs_addr = 3; bus.ex_rs_data = 0; bus.ex_rt_addr = 7; bus.ex_rt_data = 5;
    bus.wb_reg_write = 1; bus.wb_write_addr = 3; bus.wb_write_data = 99;
    settle_check();
    check("fwd_mem_wins", 32'(bus.fwd_a), FWD_ON ? 32'd2 : 32'd0);
    clock_check();
    check("fwd_result", bus.mem_alu_result, FWD_ON ? 32'd15 : 32'd5);

    // a write to r0 never forwards
    clear_inputs();
    bus.ex_rs_data = 1; bus.ex_rt_data = 1; bus.ex_reg_write = 1; bus.ex_reg_dst = 1;
    step();
    clear_inputs();
    bus.ex_rs_data = 7; bus.wb_reg_write = 1; bus.wb_write_data = 55;
    settle_check();
    check("r0_no_fwd", 32'(bus.fwd_a), 32'd0);
    clock_check();
    check("r0_result", bus.mem_alu_result, 32'd7);

    // branches: BEQ taken, BNE not, code 11 never
    for (int br = 1; br <= 3; br++) begin
      clear_inputs(); step();
      bus.ex_branch = 2'(br); bus.ex_alu_op = 4'd1; bus.ex_rs_addr = 4; bus.ex_rt_addr = 4;
      bus.ex_rs_data = 32'h55; bus.ex_rt_data = 32'h55; bus.ex_pc4 = 32'h100; bus.ex_imm = 3;
      settle_check();
      check("br_taken", 32'(bus.branch_taken), (br == 1) ? 32'd1 : 32'd0);
      check("br_target", bus.branch_target, 32'h10C);
      clock_check();
    end

    // signed vs unsigned compare, and sll
    clear_inputs();
    bus.ex_alu_op = 4'd4; bus.ex_rs_data = 32'hFFFF_FFFF; bus.ex_alu_src = 1; bus.ex_imm = 1;
    step();
    check("slt", bus.mem_alu_result, 32'd1);
    clear_inputs();
    bus.ex_alu_op = 4'hF; bus.ex_funct = 6'h2B; bus.ex_rs_data = 32'hFFFF_FFFF; bus.ex_rt_data = 1;
    step();
    check("sltu", bus.mem_alu_result, 32'd0);
    clear_inputs();
    bus.ex_alu_op = 4'hF; bus.ex_funct = 6'h00; bus.ex_rt_data = 1; bus.ex_imm = 32'd4 << 6;
    step();
    check("sll", bus.mem_alu_result, 32'h10);

    // store with rt forwarded from WB while B takes the immediate
    clear_inputs(); step();
    bus.ex_alu_op = 4'd0; bus.ex_alu_src = 1; bus.ex_imm = 8; bus.ex_mem_write = 1;
    bus.ex_rs_addr = 5; bus.ex_rs_data = 32'h1000; bus.ex_rt_addr = 6; bus.ex_rt_data = 0;
    bus.wb_reg_write = 1; bus.wb_write_addr = 6; bus.wb_write_data = 32'hABCD;
    step();
    check("store_data", bus.mem_write_data, FWD_ON ? 32'hABCD : 32'd0);
    check("store_addr", bus.mem_alu_result, 32'h1008);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 19) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
